// File: rtl/fetch_pc_unit.sv
// IF-stage PC register and instruction-fetch sequencer feeding the IF/ID register.
// Latency: instruction lands in IF/ID on the edge that samples imem_ack (1/cycle at 0-wait).
// Backpressure: stall during ack parks the word in a 1-entry skid and drops imem_req until released.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC  = 32'hBFC00000,
   parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] next_pc,
   input  logic        redirect,
   input  logic        stall,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        ifid_valid,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc4,
   output logic        misalign_err
);

   typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } ifid_t;

   state_t      state, state_nxt;
   logic [31:0] pc_q;
   ifid_t       ifid_q, ifid_nxt;
   ifid_t       skid_q, skid_nxt;
   logic        vld_q, vld_nxt;
   logic        pc_load;
   logic        err_q;

   assign pc           = pc_q;
   assign pc_plus4     = pc_q + 32'd4;
   assign imem_req     = (state == FETCH);
   assign imem_addr    = pc_q;
   assign ifid_valid   = vld_q;
   assign ifid_instr   = ifid_q.instr;
   assign ifid_pc4     = ifid_q.pc4;
   assign misalign_err = err_q;

   always_comb begin
      state_nxt = state;
      pc_load   = 1'b0;
      ifid_nxt  = ifid_q;
      skid_nxt  = skid_q;
      vld_nxt   = vld_q;
      case (state)
         BOOT: state_nxt = FETCH;
         FETCH: begin
            if (imem_ack && !stall) begin
               ifid_nxt = '{instr: imem_rdata, pc4: pc_plus4};
               vld_nxt  = 1'b1;
               pc_load  = 1'b1;
            end else if (imem_ack) begin
               skid_nxt  = '{instr: imem_rdata, pc4: pc_plus4};
               state_nxt = HOLD;
            end else if (!stall) begin
               vld_nxt = 1'b0;
            end
         end
         HOLD: begin
            if (!stall) begin
               ifid_nxt  = skid_q;
               vld_nxt   = 1'b1;
               pc_load   = 1'b1;
               state_nxt = FETCH;
            end
         end
         default: state_nxt = BOOT;
      endcase
      // Redirect beats stall and ack; any in-flight or parked word is discarded.
      if (redirect && state != BOOT) begin
         pc_load        = 1'b1;
         vld_nxt        = 1'b0;
         ifid_nxt.instr = NOP_INSTR;
         skid_nxt       = '0;
         state_nxt      = FETCH;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= BOOT;
         pc_q   <= RESET_PC;
         ifid_q <= '{instr: NOP_INSTR, pc4: 32'd0};
         skid_q <= '0;
         vld_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         ifid_q <= ifid_nxt;
         skid_q <= skid_nxt;
         vld_q  <= vld_nxt;
         err_q  <= pc_load && (next_pc[1:0] != 2'b00);
         if (pc_load)
            pc_q <= {next_pc[31:2], 2'b00};
      end
   end

endmodule
